if_fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32 pipeline: PC register, imem request/ack handshake and IF/ID pipeline register.

---
 rtl/if_fetch_stage_if.sv | 22 ++
 rtl/if_fetch_stage.sv | 196 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the IF stage (master) and imem (slave).
// imem_ack may be asserted combinationally in the same cycle as imem_req.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage RV32 pipeline: PC register, imem request/ack handshake
// and the IF/ID pipeline register. Tolerates variable imem latency and parks a
// returned instruction in a holding buffer while ID is stalled.
// Optional feature: define IF_PERF_CNT_EN to build the fetch/bubble counters;
// otherwise cnt_fetch and cnt_bubble are tied to zero.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_EN_IF,
    input  logic             reg_FD_EN,
    input  logic             reg_FD_stall,
    input  logic             reg_FD_flush,
    input  logic [31:0]      PC_branch_ID,
    if_fetch_stage_if.master imem,
    output logic [31:0]      PC_IF,
    output logic [31:0]      PC_ID,
    output logic [31:0]      inst_ID,
    output logic             valid_ID,
    output logic             fetch_busy,
    output logic [31:0]      cnt_fetch,
    output logic [31:0]      cnt_bubble
);

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc_id_q;
    logic [31:0] inst_id_q;
    logic        valid_id_q;

    logic        req;
    logic        wr_en;
    logic        flush_eff;
    logic        advance;
    logic        id_load;
    logic        id_bubble;
    logic [31:0] id_data;

    // A stalled or disabled IF/ID register swallows any flush.
    assign wr_en     = reg_FD_EN & ~reg_FD_stall;
    assign flush_eff = wr_en & reg_FD_flush;
    assign advance   = wr_en & PC_EN_IF;

    // Next-state, PC redirect and IF/ID load decisions.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        tgt_d     = tgt_q;
        req       = 1'b0;
        id_load   = 1'b0;
        id_bubble = 1'b0;
        id_data   = imem.imem_rdata;

        unique case (state_q)
            StFetch: begin
                req = 1'b1;
                if (flush_eff) begin
                    id_bubble = 1'b1;
                    if (imem.imem_ack) begin
                        pc_d = PC_branch_ID;
                    end else begin
                        // Request in flight: let it finish, redirect afterwards.
                        tgt_d   = PC_branch_ID;
                        state_d = StDiscard;
                    end
                end else if (imem.imem_ack) begin
                    if (advance) begin
                        id_load = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end else begin
                        buf_d   = imem.imem_rdata;
                        state_d = StHold;
                    end
                end else if (advance) begin
                    id_bubble = 1'b1;
                end
            end
            StHold: begin
                id_data = buf_q;
                if (flush_eff) begin
                    id_bubble = 1'b1;
                    pc_d      = PC_branch_ID;
                    state_d   = StFetch;
                end else if (advance) begin
                    id_load = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                req = 1'b1;
                if (flush_eff) begin
                    id_bubble = 1'b1;
                    if (imem.imem_ack) begin
                        pc_d    = PC_branch_ID;
                        state_d = StFetch;
                    end else begin
                        tgt_d = PC_branch_ID;
                    end
                end else begin
                    if (advance) begin
                        id_bubble = 1'b1;
                    end
                    // Completing the stale request always redirects, so the
                    // dropped address is never re-fetched.
                    if (imem.imem_ack) begin
                        pc_d    = tgt_q;
                        state_d = StFetch;
                    end
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // FSM, PC, holding buffer and redirect target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            tgt_q   <= tgt_d;
        end
    end

    // IF/ID pipeline register; a bubble keeps PC_ID and clears valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_id_q    <= 32'h0;
            inst_id_q  <= NOP_INST;
            valid_id_q <= 1'b0;
        end else if (id_load) begin
            pc_id_q    <= pc_q;
            inst_id_q  <= id_data;
            valid_id_q <= 1'b1;
        end else if (id_bubble) begin
            inst_id_q  <= NOP_INST;
            valid_id_q <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] cnt_fetch_q;
    logic [31:0] cnt_bubble_q;

    // Performance counters; loads already require reg_FD_EN so they freeze with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_fetch_q  <= 32'h0;
            cnt_bubble_q <= 32'h0;
        end else begin
            if (id_load) begin
                cnt_fetch_q <= cnt_fetch_q + 32'd1;
            end
            if (id_bubble) begin
                cnt_bubble_q <= cnt_bubble_q + 32'd1;
            end
        end
    end

    assign cnt_fetch  = cnt_fetch_q;
    assign cnt_bubble = cnt_bubble_q;
`else
    assign cnt_fetch  = 32'h0;
    assign cnt_bubble = 32'h0;
`endif

    // No request leaves the stage during a reset cycle.
    assign imem.imem_req  = req & ~rst;
    assign imem.imem_addr = {pc_q[31:2], 2'b00};
    assign fetch_busy     = req & ~rst & ~imem.imem_ack;

    assign PC_IF    = pc_q;
    assign PC_ID    = pc_id_q;
    assign inst_ID  = inst_id_q;
    assign valid_ID = valid_id_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios with literal checks, plus a
// per-cycle comparison against a behavioural model of the fetch stage.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        fd_en;
    logic        fd_stall;
    logic        fd_flush;
    logic [31:0] branch;
    logic [31:0] pc_if, pc_id, inst_id, cnt_fetch, cnt_bubble;
    logic        valid_id, fetch_busy;

    int n_checks = 0;
    int n_err    = 0;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .PC_EN_IF     (pc_en),
        .reg_FD_EN    (fd_en),
        .reg_FD_stall (fd_stall),
        .reg_FD_flush (fd_flush),
        .PC_branch_ID (branch),
        .imem         (bus.master),
        .PC_IF        (pc_if),
        .PC_ID        (pc_id),
        .inst_ID      (inst_id),
        .valid_ID     (valid_id),
        .fetch_busy   (fetch_busy),
        .cnt_fetch    (cnt_fetch),
        .cnt_bubble   (cnt_bubble)
    );

    always #5 clk = ~clk;

    // imem: fixed latency in cycles counted from request start; data derived from address.
    int unsigned mem_lat = 0;
    int unsigned lat_cnt;

    always_comb begin
        bus.imem_ack   = bus.imem_req && (lat_cnt >= mem_lat);
        bus.imem_rdata = 32'hC0DE_0000 | bus.imem_addr;
    end

    always @(posedge clk) begin
        if (rst)                               lat_cnt <= 0;
        else if (bus.imem_req && bus.imem_ack) lat_cnt <= 0;
        else if (bus.imem_req)                 lat_cnt <= lat_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: instruction availability, pending redirect and the ID contents.
    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_pc_id, m_inst, m_hdata, m_tgt, m_cf, m_cb, m_data;
    logic        m_valid, m_held, m_drop;
    logic        m_req, m_wr, m_fl, m_adv, m_have, m_ack;

    always @(negedge clk) begin
        #2;
        m_ack = bus.imem_ack;
        if (rst) begin
            chk("req_during_rst", {31'b0, bus.imem_req}, 32'd0);
        end else if (m_known) begin
            m_req = !m_held;
            chk("imem_req",   {31'b0, bus.imem_req}, {31'b0, m_req});
            chk("imem_addr",  bus.imem_addr, {m_pc[31:2], 2'b00});
            chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, m_req && !m_ack});
            chk("PC_IF",      pc_if, m_pc);
            chk("PC_ID",      pc_id, m_pc_id);
            chk("inst_ID",    inst_id, m_inst);
            chk("valid_ID",   {31'b0, valid_id}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
            chk("cnt_fetch",  cnt_fetch, m_cf);
            chk("cnt_bubble", cnt_bubble, m_cb);
`else
            chk("cnt_fetch",  cnt_fetch, 32'h0);
            chk("cnt_bubble", cnt_bubble, 32'h0);
`endif
        end

        if (rst) begin
            m_known = 1'b1;
            m_pc = 32'h0; m_pc_id = 32'h0; m_inst = NOP; m_valid = 1'b0;
            m_held = 1'b0; m_drop = 1'b0; m_tgt = 32'h0; m_cf = 32'h0; m_cb = 32'h0;
        end else if (m_known) begin
            m_req  = !m_held;
            m_wr   = fd_en && !fd_stall;
            m_fl   = m_wr && fd_flush;
            m_adv  = m_wr && pc_en;
            m_have = m_held || (m_req && m_ack && !m_drop);
            m_data = m_held ? m_hdata : bus.imem_rdata;
            if (m_fl) begin
                m_inst = NOP; m_valid = 1'b0; m_cb = m_cb + 1;
                if (m_req && !m_ack) begin
                    m_drop = 1'b1; m_tgt = branch;
                end else begin
                    m_pc = branch; m_drop = 1'b0; m_held = 1'b0;
                end
            end else if (m_drop) begin
                if (m_adv) begin
                    m_inst = NOP; m_valid = 1'b0; m_cb = m_cb + 1;
                end
                if (m_ack) begin
                    m_pc = m_tgt; m_drop = 1'b0;
                end
            end else if (m_have && m_adv) begin
                m_pc_id = m_pc; m_inst = m_data; m_valid = 1'b1; m_cf = m_cf + 1;
                m_pc = m_pc + 32'd4; m_held = 1'b0;
            end else if (m_have) begin
                m_hdata = m_data; m_held = 1'b1;
            end else if (m_adv) begin
                m_inst = NOP; m_valid = 1'b0; m_cb = m_cb + 1;
            end
        end
    end

    task automatic tick(input logic s, input logic f, input logic [31:0] b, input logic en);
        @(negedge clk);
        rst = 1'b0; fd_stall = s; fd_flush = f; branch = b; fd_en = en; pc_en = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset(input int unsigned lat);
        @(negedge clk);
        rst = 1'b1; fd_stall = 1'b0; fd_flush = 1'b0; branch = 32'h0;
        fd_en = 1'b1; pc_en = 1'b1; mem_lat = lat;
        settle();
        chk("lit_rst_req", {31'b0, bus.imem_req}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pc_en = 1'b1; fd_en = 1'b1; fd_stall = 1'b0; fd_flush = 1'b0; branch = 32'h0;

        // Zero-wait imem: one instruction per cycle.
        do_reset(0);
        tick(0, 0, 32'h0, 1); settle();
        chk("lit_reset_pc", pc_if, 32'h0);
        chk("lit_reset_valid", {31'b0, valid_id}, 32'd0);
        chk("lit_reset_inst", inst_id, NOP);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 32'h0, 1); settle();
            chk("lit_b2b_pc_id", pc_id, 32'(4 * i));
            chk("lit_b2b_valid", {31'b0, valid_id}, 32'd1);
            chk("lit_b2b_inst", inst_id, 32'hC0DE_0000 | 32'(4 * i));
        end

        // Two-cycle latency: each instruction followed by two bubbles.
        do_reset(2);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_lat2_busy0", {31'b0, fetch_busy}, 32'd1);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_lat2_busy1", {31'b0, fetch_busy}, 32'd1);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_lat2_ackcyc", {31'b0, fetch_busy}, 32'd0);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_lat2_pc0", pc_id, 32'h0);
        chk("lit_lat2_v0", {31'b0, valid_id}, 32'd1);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_lat2_bub1", inst_id, NOP);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_lat2_bub2", {31'b0, valid_id}, 32'd0);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_lat2_pc4", pc_id, 32'h4);

        // Stall for three cycles while PC 8 is acknowledged.
        do_reset(0);
        run(2);
        tick(1, 0, 32'h0, 1); settle(); chk("lit_stall_pc8", pc_if, 32'h8);
        tick(1, 0, 32'h0, 1); settle(); chk("lit_hold_req", {31'b0, bus.imem_req}, 32'd0);
        chk("lit_hold_pc_id", pc_id, 32'h4);
        tick(1, 0, 32'h0, 1); settle(); chk("lit_hold_req2", {31'b0, bus.imem_req}, 32'd0);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_release_pc_id", pc_id, 32'h4);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_after_pc_id", pc_id, 32'h8);
        chk("lit_after_inst", inst_id, 32'hC0DE_0008);

        // Flush with same-cycle ack.
        do_reset(0);
        run(1);
        tick(0, 1, 32'h100, 1);
        tick(0, 0, 32'h0, 1); settle();
        chk("lit_flush_bubble", {31'b0, valid_id}, 32'd0);
        chk("lit_flush_addr", bus.imem_addr, 32'h100);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_flush_pc_id", pc_id, 32'h100);

        // Flush while a 3-cycle fetch at 0x20 is outstanding.
        do_reset(0);
        run(8);
        tick(0, 1, 32'h100, 1); mem_lat = 3; settle();
        chk("lit_disc_addr0", bus.imem_addr, 32'h20);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_disc_addr1", bus.imem_addr, 32'h20);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_disc_addr2", bus.imem_addr, 32'h20);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_disc_ack", {31'b0, fetch_busy}, 32'd0);
        tick(0, 0, 32'h0, 1); mem_lat = 0; settle();
        chk("lit_disc_new_addr", bus.imem_addr, 32'h100);
        chk("lit_disc_dropped", {31'b0, valid_id}, 32'd0);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_disc_pc_id", pc_id, 32'h100);

        // Reset while in the discard state.
        do_reset(3);
        run(1);
        tick(0, 1, 32'h40, 1);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_disc_req", {31'b0, bus.imem_req}, 32'd1);
        do_reset(3);
        tick(0, 0, 32'h0, 1); settle();
        chk("lit_rst_pc", pc_if, 32'h0);
        chk("lit_rst_valid", {31'b0, valid_id}, 32'd0);
        chk("lit_rst_cnt_fetch", cnt_fetch, 32'h0);
        chk("lit_rst_cnt_bubble", cnt_bubble, 32'h0);
        run(3);

        // PC wrap, then IF/ID enable dropped while an ack arrives.
        do_reset(0);
        tick(0, 1, 32'hFFFF_FFFC, 1);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_wrap_pc_hi", pc_if, 32'hFFFF_FFFC);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_wrap_pc_lo", pc_if, 32'h0);
        chk("lit_wrap_pc_id", pc_id, 32'hFFFF_FFFC);
        tick(0, 0, 32'h0, 0);
        tick(0, 0, 32'h0, 0); settle(); chk("lit_en0_req", {31'b0, bus.imem_req}, 32'd0);
        chk("lit_en0_pc_id", pc_id, 32'h0);
        tick(0, 0, 32'h0, 1);
        tick(0, 0, 32'h0, 1); settle(); chk("lit_en1_pc_id", pc_id, 32'h4);
        run(2);

        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
